// File: rtl/calc2_pkg.sv
// Shared types and constants for the CALC2 port initiator and its tag pool.
package calc2_pkg;

  localparam int unsigned TAG_W   = 2;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned N_TAGS  = 4;
  localparam int unsigned CMD_W   = 4;
  localparam int unsigned RESP_W  = 2;
  localparam int unsigned TIMER_W = 8;

  typedef enum logic [CMD_W-1:0] {
    CmdNop = 4'd0,
    CmdAdd = 4'd1,
    CmdSub = 4'd2,
    CmdShl = 4'd5,
    CmdShr = 4'd6
  } cmd_e;

  typedef enum logic [RESP_W-1:0] {
    RespNone = 2'd0,
    RespOk   = 2'd1,
    RespErr  = 2'd2,
    RespRsvd = 2'd3
  } resp_e;

  // Response code the DUT must never produce; reported but flagged.
  localparam logic [RESP_W-1:0] RESP_RESERVED = RespRsvd;

  typedef enum logic {
    StIdle,
    StOp2
  } state_e;

endpackage

// File: rtl/calc2_tag_pool.sv
// Tag bookkeeping: busy flags, lowest-free allocation, per-tag command and
// second-operand slots, and per-tag age timers that reclaim stale tags.
module calc2_tag_pool
  import calc2_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_alloc,
  input  logic [CMD_W-1:0]  i_alloc_cmd,
  input  logic [DATA_W-1:0] i_alloc_data2,
  input  logic              i_rsp,
  input  logic [TAG_W-1:0]  i_rsp_tag,
  input  logic [TAG_W-1:0]  i_rd_tag,
  output logic [N_TAGS-1:0] o_busy,
  output logic              o_any_free,
  output logic [TAG_W-1:0]  o_free_tag,
  output logic [CMD_W-1:0]  o_rsp_cmd,
  output logic [DATA_W-1:0] o_rd_data2,
  output logic [N_TAGS-1:0] o_timeout
);

  // Timer value seen in the cycle before it would reach TIMEOUT.
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT - 1);

  logic [N_TAGS-1:0]  r_busy;
  logic [N_TAGS-1:0]  r_timeout;
  logic [CMD_W-1:0]   r_cmd   [N_TAGS];
  logic [DATA_W-1:0]  r_data2 [N_TAGS];
  logic [TIMER_W-1:0] r_timer [N_TAGS];

  logic [N_TAGS-1:0]  w_release;
  logic [N_TAGS-1:0]  w_expire;
  logic [TAG_W-1:0]   w_free_tag;
  logic               w_any_free;

  // Lowest-index free tag wins.
  always_comb begin
    w_free_tag = '0;
    w_any_free = 1'b0;
    for (int i = int'(N_TAGS) - 1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        w_free_tag = TAG_W'(i);
        w_any_free = 1'b1;
      end
    end
  end

  // A response on a busy tag releases it and masks a coincident expiry.
  always_comb begin
    w_release = '0;
    w_expire  = '0;
    for (int i = 0; i < int'(N_TAGS); i++) begin
      w_release[i] = i_rsp && (i_rsp_tag == TAG_W'(i)) && r_busy[i];
      w_expire[i]  = r_busy[i] && (r_timer[i] == TIMEOUT_LAST) && !w_release[i];
    end
  end

  // Per-tag state: allocate, release, expire or age.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_busy    <= '0;
      r_timeout <= '0;
      for (int i = 0; i < int'(N_TAGS); i++) begin
        r_cmd[i]   <= '0;
        r_data2[i] <= '0;
        r_timer[i] <= '0;
      end
    end else begin
      r_timeout <= w_expire;
      for (int i = 0; i < int'(N_TAGS); i++) begin
        if (i_alloc && (w_free_tag == TAG_W'(i))) begin
          r_busy[i]  <= 1'b1;
          r_timer[i] <= '0;
          r_cmd[i]   <= i_alloc_cmd;
          r_data2[i] <= i_alloc_data2;
        end else if (w_release[i] || w_expire[i]) begin
          r_busy[i]  <= 1'b0;
          r_timer[i] <= '0;
        end else if (r_busy[i]) begin
          r_timer[i] <= r_timer[i] + 8'd1;
        end
      end
    end
  end

  assign o_busy     = r_busy;
  assign o_any_free = w_any_free;
  assign o_free_tag = w_free_tag;
  assign o_rsp_cmd  = r_cmd[i_rsp_tag];
  assign o_rd_data2 = r_data2[i_rd_tag];
  assign o_timeout  = r_timeout;

endmodule

// File: rtl/calc2_port_initiator.sv
// Drives one CALC2 request port: serialises accepted operations into a
// two-beat request, tracks tags, and returns tagged responses.
module calc2_port_initiator
  import calc2_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [CMD_W-1:0]  op_cmd,
  input  logic [DATA_W-1:0] op_data1,
  input  logic [DATA_W-1:0] op_data2,
  output logic [CMD_W-1:0]  req_cmd_in,
  output logic [DATA_W-1:0] req_data_in,
  output logic [TAG_W-1:0]  req_tag_in,
  input  logic [RESP_W-1:0] out_resp,
  input  logic [DATA_W-1:0] out_data,
  input  logic [TAG_W-1:0]  out_tag,
  output logic              res_valid,
  output logic [RESP_W-1:0] res_resp,
  output logic [DATA_W-1:0] res_data,
  output logic [TAG_W-1:0]  res_tag,
  output logic [CMD_W-1:0]  res_cmd,
  output logic              err_unexpected,
  output logic [N_TAGS-1:0] timeout_tags
);

  state_e            r_state;
  logic [CMD_W-1:0]  r_req_cmd;
  logic [DATA_W-1:0] r_req_data;
  logic [TAG_W-1:0]  r_req_tag;
  logic              r_res_valid;
  logic [RESP_W-1:0] r_res_resp;
  logic [DATA_W-1:0] r_res_data;
  logic [TAG_W-1:0]  r_res_tag;
  logic [CMD_W-1:0]  r_res_cmd;
  logic              r_err;

  logic              w_accept;
  logic              w_issue;
  logic              w_rsp;
  logic              w_any_free;
  logic [TAG_W-1:0]  w_free_tag;
  logic [N_TAGS-1:0] w_busy;
  logic [N_TAGS-1:0] w_timeout;
  logic [CMD_W-1:0]  w_rsp_cmd;
  logic [DATA_W-1:0] w_rd_data2;

  // Gated by reset so op_ready stays low until reset is released.
  assign op_ready = (r_state == StIdle) && w_any_free && !reset;
  assign w_accept = op_valid && op_ready;
  // A no-op is consumed without allocating a tag or issuing a request.
  assign w_issue  = w_accept && (op_cmd != CmdNop);
  assign w_rsp    = (out_resp != RespNone);

  calc2_tag_pool #(
    .TIMEOUT (TIMEOUT)
  ) u_tag_pool (
    .i_clk         (c_clk),
    .i_reset       (reset),
    .i_alloc       (w_issue),
    .i_alloc_cmd   (op_cmd),
    .i_alloc_data2 (op_data2),
    .i_rsp         (w_rsp),
    .i_rsp_tag     (out_tag),
    .i_rd_tag      (r_req_tag),
    .o_busy        (w_busy),
    .o_any_free    (w_any_free),
    .o_free_tag    (w_free_tag),
    .o_rsp_cmd     (w_rsp_cmd),
    .o_rd_data2    (w_rd_data2),
    .o_timeout     (w_timeout)
  );

  // Request FSM: beat 1 carries cmd/data1/tag, beat 2 carries data2 with cmd 0.
  always_ff @(posedge c_clk) begin
    if (reset) begin
      r_state    <= StIdle;
      r_req_cmd  <= '0;
      r_req_data <= '0;
      r_req_tag  <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_issue) begin
            r_req_cmd  <= op_cmd;
            r_req_data <= op_data1;
            r_req_tag  <= w_free_tag;
            r_state    <= StOp2;
          end else begin
            r_req_cmd  <= '0;
            r_req_data <= '0;
            r_req_tag  <= '0;
          end
        end
        StOp2: begin
          r_req_cmd  <= '0;
          r_req_data <= w_rd_data2;
          r_state    <= StIdle;
        end
      endcase
    end
  end

  // Response capture; unknown tags and the reserved code raise err_unexpected.
  always_ff @(posedge c_clk) begin
    if (reset) begin
      r_res_valid <= 1'b0;
      r_res_resp  <= '0;
      r_res_data  <= '0;
      r_res_tag   <= '0;
      r_res_cmd   <= '0;
      r_err       <= 1'b0;
    end else if (w_rsp) begin
      r_res_valid <= 1'b1;
      r_res_resp  <= out_resp;
      r_res_data  <= out_data;
      r_res_tag   <= out_tag;
      r_res_cmd   <= w_busy[out_tag] ? w_rsp_cmd : '0;
      r_err       <= !w_busy[out_tag] || (out_resp == RESP_RESERVED);
    end else begin
      r_res_valid <= 1'b0;
      r_res_resp  <= '0;
      r_res_data  <= '0;
      r_res_tag   <= '0;
      r_res_cmd   <= '0;
      r_err       <= 1'b0;
    end
  end

  assign req_cmd_in     = r_req_cmd;
  assign req_data_in    = r_req_data;
  assign req_tag_in     = r_req_tag;
  assign res_valid      = r_res_valid;
  assign res_resp       = r_res_resp;
  assign res_data       = r_res_data;
  assign res_tag        = r_res_tag;
  assign res_cmd        = r_res_cmd;
  assign err_unexpected = r_err;
  assign timeout_tags   = w_timeout;

endmodule

// File: tb/tb_calc2_port_initiator.sv
// Directed scenarios plus randomized traffic, checked every cycle against a
// transaction-level model that tracks tags by issue time.
module tb_calc2_port_initiator;

  localparam int unsigned TO = 10;

  logic        c_clk = 1'b0;
  logic        reset = 1'b1;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [3:0]  op_cmd = '0;
  logic [31:0] op_data1 = '0;
  logic [31:0] op_data2 = '0;
  logic [3:0]  req_cmd_in;
  logic [31:0] req_data_in;
  logic [1:0]  req_tag_in;
  logic [1:0]  out_resp = '0;
  logic [31:0] out_data = '0;
  logic [1:0]  out_tag = '0;
  logic        res_valid;
  logic [1:0]  res_resp;
  logic [31:0] res_data;
  logic [1:0]  res_tag;
  logic [3:0]  res_cmd;
  logic        err_unexpected;
  logic [3:0]  timeout_tags;

  always #5 c_clk = ~c_clk;

  calc2_port_initiator #(
    .TIMEOUT (TO)
  ) dut (
    .c_clk          (c_clk),
    .reset          (reset),
    .op_valid       (op_valid),
    .op_ready       (op_ready),
    .op_cmd         (op_cmd),
    .op_data1       (op_data1),
    .op_data2       (op_data2),
    .req_cmd_in     (req_cmd_in),
    .req_data_in    (req_data_in),
    .req_tag_in     (req_tag_in),
    .out_resp       (out_resp),
    .out_data       (out_data),
    .out_tag        (out_tag),
    .res_valid      (res_valid),
    .res_resp       (res_resp),
    .res_data       (res_data),
    .res_tag        (res_tag),
    .res_cmd        (res_cmd),
    .err_unexpected (err_unexpected),
    .timeout_tags   (timeout_tags)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: set of outstanding tags with their command and issue cycle.
  logic [3:0]  m_busy = '0;
  logic [3:0]  m_cmd [4];
  int          m_issue [4];
  int          m_cyc = 0;
  bit          m_op2 = 1'b0;
  logic [1:0]  m_ptag = '0;
  logic [31:0] m_pd2 = '0;

  logic [3:0]  e_req_cmd = '0;
  logic [31:0] e_req_data = '0;
  logic [1:0]  e_req_tag = '0;
  logic        e_res_valid = 1'b0;
  logic [1:0]  e_res_resp = '0;
  logic [31:0] e_res_data = '0;
  logic [1:0]  e_res_tag = '0;
  logic [3:0]  e_res_cmd = '0;
  logic        e_err = 1'b0;
  logic [3:0]  e_to = '0;

  function automatic void model_edge();
    int  lowest;
    bit  ready;
    bit  hit;
    bit  alloc;
    lowest = -1;
    hit    = 1'b0;
    alloc  = 1'b0;
    m_cyc++;
    if (reset) begin
      m_busy = '0; m_op2 = 1'b0;
      e_req_cmd = '0; e_req_data = '0; e_req_tag = '0;
      e_res_valid = 1'b0; e_res_resp = '0; e_res_data = '0; e_res_tag = '0;
      e_res_cmd = '0; e_err = 1'b0; e_to = '0;
      return;
    end
    for (int t = 0; t < 4; t++) if (!m_busy[t] && lowest < 0) lowest = t;
    ready = !m_op2 && (lowest >= 0);
    if (out_resp != 2'd0) begin
      hit = m_busy[out_tag];
      e_res_valid = 1'b1; e_res_resp = out_resp; e_res_data = out_data; e_res_tag = out_tag;
      e_res_cmd = hit ? m_cmd[out_tag] : 4'd0;
      e_err = !hit || (out_resp == 2'd3);
    end else begin
      e_res_valid = 1'b0; e_res_resp = '0; e_res_data = '0; e_res_tag = '0;
      e_res_cmd = '0; e_err = 1'b0;
    end
    e_to = '0;
    for (int t = 0; t < 4; t++)
      if (m_busy[t] && (m_cyc - m_issue[t] == int'(TO)) && !(hit && out_tag == 2'(t)))
        e_to[t] = 1'b1;
    if (m_op2) begin
      e_req_cmd = '0; e_req_data = m_pd2; e_req_tag = m_ptag; m_op2 = 1'b0;
    end else if (ready && op_valid && op_cmd != 4'd0) begin
      e_req_cmd = op_cmd; e_req_data = op_data1; e_req_tag = 2'(lowest);
      m_ptag = 2'(lowest); m_pd2 = op_data2; m_op2 = 1'b1; alloc = 1'b1;
    end else begin
      e_req_cmd = '0; e_req_data = '0; e_req_tag = '0;
    end
    if (hit) m_busy[out_tag] = 1'b0;
    m_busy = m_busy & ~e_to;
    if (alloc) begin
      m_busy[lowest] = 1'b1; m_cmd[lowest] = op_cmd; m_issue[lowest] = m_cyc;
    end
  endfunction

  // One clock: model follows the edge, outputs compared half a cycle later.
  task automatic step();
    @(posedge c_clk);
    model_edge();
    @(negedge c_clk);
    check_eq("op_ready", op_ready, !reset && !m_op2 && (m_busy != 4'hf));
    check_eq("req_cmd", req_cmd_in, e_req_cmd);
    check_eq("req_data", req_data_in, e_req_data);
    check_eq("req_tag", req_tag_in, e_req_tag);
    check_eq("res_valid", res_valid, e_res_valid);
    check_eq("res_resp", res_resp, e_res_resp);
    check_eq("res_data", res_data, e_res_data);
    check_eq("res_tag", res_tag, e_res_tag);
    check_eq("res_cmd", res_cmd, e_res_cmd);
    check_eq("err_unexpected", err_unexpected, e_err);
    check_eq("timeout_tags", timeout_tags, e_to);
  endtask

  task automatic set_op(input logic v, input logic [3:0] c, input logic [31:0] d1,
                        input logic [31:0] d2);
    op_valid = v; op_cmd = c; op_data1 = d1; op_data2 = d2;
  endtask

  task automatic respond(input logic [1:0] r, input logic [31:0] d, input logic [1:0] t);
    out_resp = r; out_data = d; out_tag = t;
  endtask

  task automatic do_reset();
    reset = 1'b1; set_op(1'b0, 4'd0, 32'd0, 32'd0); respond(2'd0, 32'd0, 2'd0);
    step();
    reset = 1'b0;
    step();
  endtask

  logic [3:0] cmds [4];

  initial begin
    cmds[0] = 4'd1; cmds[1] = 4'd2; cmds[2] = 4'd5; cmds[3] = 4'd6;

    // Reset state
    step(); step();
    check_eq("rst_ready", op_ready, 32'd0);
    check_eq("rst_req_cmd", req_cmd_in, 32'd0);
    reset = 1'b0;
    step();
    check_eq("ready_after_rst", op_ready, 32'd1);

    // Single add
    set_op(1'b1, 4'd1, 32'h10, 32'h22);
    step();
    check_eq("add_b1_cmd", req_cmd_in, 32'd1);
    check_eq("add_b1_data", req_data_in, 32'h10);
    check_eq("add_b1_tag", req_tag_in, 32'd0);
    set_op(1'b0, 4'd0, 32'd0, 32'd0);
    step();
    check_eq("add_b2_cmd", req_cmd_in, 32'd0);
    check_eq("add_b2_data", req_data_in, 32'h22);
    respond(2'd1, 32'h32, 2'd0);
    step();
    respond(2'd0, 32'd0, 2'd0);
    check_eq("add_res_valid", res_valid, 32'd1);
    check_eq("add_res_data", res_data, 32'h32);
    check_eq("add_res_cmd", res_cmd, 32'd1);
    step();

    // Tag exhaustion, then a freed tag 2 is reused
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_op(1'b1, cmds[i % 4], $urandom, $urandom);
      step();
    end
    check_eq("exhaust_ready", op_ready, 32'd0);
    respond(2'd1, 32'h5, 2'd2);
    step();
    respond(2'd0, 32'd0, 2'd0);
    step();
    check_eq("reuse_tag", req_tag_in, 32'd2);
    set_op(1'b0, 4'd0, 32'd0, 32'd0);
    step();

    // Out-of-order responses 3, 0, 1
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_op(i % 2 == 0, cmds[i / 2], $urandom, $urandom);
      step();
    end
    set_op(1'b0, 4'd0, 32'd0, 32'd0);
    respond(2'd1, 32'h33, 2'd3); step();
    check_eq("ooo_tag3", res_tag, 32'd3); check_eq("ooo_cmd3", res_cmd, 32'd6);
    respond(2'd1, 32'h44, 2'd0); step();
    check_eq("ooo_tag0", res_tag, 32'd0); check_eq("ooo_cmd0", res_cmd, 32'd1);
    respond(2'd2, 32'h55, 2'd1); step();
    check_eq("ooo_tag1", res_tag, 32'd1); check_eq("ooo_cmd1", res_cmd, 32'd2);
    respond(2'd0, 32'd0, 2'd0);
    step();

    // Timeout exactly TO cycles after issue, then a late response
    do_reset();
    set_op(1'b1, 4'd2, 32'h7, 32'h3);
    step();
    set_op(1'b0, 4'd0, 32'd0, 32'd0);
    for (int i = 1; i <= int'(TO); i++) begin
      step();
      check_eq("to_pulse", timeout_tags, (i == int'(TO)) ? 32'd1 : 32'd0);
    end
    respond(2'd1, 32'h9, 2'd0);
    step();
    respond(2'd0, 32'd0, 2'd0);
    check_eq("late_err", err_unexpected, 32'd1);
    check_eq("late_cmd", res_cmd, 32'd0);

    // Response and timeout collide on the same tag
    do_reset();
    set_op(1'b1, 4'd5, 32'h1, 32'h4);
    step();
    set_op(1'b0, 4'd0, 32'd0, 32'd0);
    for (int i = 1; i < int'(TO); i++) step();
    respond(2'd1, 32'h10, 2'd0);
    step();
    respond(2'd0, 32'd0, 2'd0);
    check_eq("coll_valid", res_valid, 32'd1);
    check_eq("coll_to", timeout_tags, 32'd0);

    // Reset during the second beat
    do_reset();
    set_op(1'b1, 4'd1, 32'hA, 32'hB); step(); step();
    set_op(1'b1, 4'd2, 32'hC, 32'hD); step();
    reset = 1'b1; set_op(1'b0, 4'd0, 32'd0, 32'd0);
    step();
    check_eq("rst_op2_cmd", req_cmd_in, 32'd0);
    check_eq("rst_op2_data", req_data_in, 32'd0);
    reset = 1'b0;
    step();
    check_eq("rst_op2_ready", op_ready, 32'd1);
    set_op(1'b1, 4'd6, 32'hE, 32'hF);
    step();
    check_eq("rst_op2_tag", req_tag_in, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic [3:0] c;
      reset = ($urandom_range(0, 99) == 0);
      case ($urandom_range(0, 5))
        0: c = 4'd0;
        1: c = 4'd1;
        2: c = 4'd2;
        3: c = 4'd5;
        4: c = 4'd6;
        default: c = 4'($urandom_range(0, 15));
      endcase
      set_op($urandom_range(0, 1) == 1, c, $urandom, $urandom);
      if ($urandom_range(0, 9) < 3) respond(2'($urandom_range(1, 3)), $urandom, 2'($urandom_range(0, 3)));
      else respond(2'd0, 32'd0, 2'd0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
